acq_doppler_sched: RTL and testbench
====================================

ACQ_DOPPLER_SCHED -- requirements
Module: acq_doppler_sched

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32, FCW width.
REQ-002 SHALL have parameter CORR_WIDTH, default 32, correlation peak width.
REQ-003 SHALL have parameter PRN_PHS_WIDTH, default 14, code-phase width.
REQ-004 SHALL have parameter HALF_BINS, default 4, Doppler bins each side of zero (total 2*HALF_BINS+1).
REQ-005 SHALL have parameter MAX_SWEEPS, default 3, full sweeps before failure.
REQ-006 SHALL have ports: rx_clk in 1, the single clock; rx_rst in 1, synchronous active-high reset.
REQ-007 SHALL have ports: rx_start in 1, start pulse; rx_abort in 1, return to IDLE; rx_trk_lost in 1, tracking loss pulse.
REQ-008 SHALL have ports: rx_bin_step in ACC_WIDTH, FCW per bin; rx_threshold in CORR_WIDTH, detection threshold.
REQ-009 SHALL have ports: rx_acq_done in 1, engine dwell-complete pulse; rx_acq_peak in CORR_WIDTH; rx_acq_phs in PRN_PHS_WIDTH.
REQ-010 SHALL have ports: tx_acq_rst out 1, engine reset; tx_car_fcw out ACC_WIDTH, Doppler offset to engine; tx_trk_start out 1, one-cycle handoff pulse.
REQ-011 SHALL have ports: tx_trk_fcw out ACC_WIDTH, locked Doppler; tx_trk_phs out PRN_PHS_WIDTH, locked code phase; tx_busy, tx_locked, tx_fail out 1 each.

Function
REQ-012 SHALL implement states IDLE, ARM, DWELL, EVAL, LOCK, FAIL.
REQ-013 IDLE: tx_acq_rst=1; on rx_start go ARM, clear best_peak=0, sweep=0, bin=-HALF_BINS.
REQ-014 ARM: tx_acq_rst=1 for exactly 2 cycles with tx_car_fcw already set for current bin, then DWELL.
REQ-015 tx_car_fcw SHALL equal bin*rx_bin_step as two's complement, truncated to ACC_WIDTH (modulo wrap, no saturation).
REQ-016 DWELL: tx_acq_rst=0; wait for rx_acq_done; no timeout.
REQ-017 On rx_acq_done in DWELL, register peak/phs and go EVAL next cycle.
REQ-018 EVAL: if peak > best_peak (strict), update best_peak, best_phs, best_fcw; equal peaks keep earlier bin.
REQ-019 EVAL, bin<HALF_BINS: bin+1, go ARM.
REQ-020 EVAL, last bin: if best_peak > rx_threshold (strict) go LOCK; else sweep+1, reset best/bin, go ARM; if sweep+1 == MAX_SWEEPS go FAIL.
REQ-021 LOCK entry: tx_trk_start high exactly one cycle; tx_trk_fcw=best_fcw, tx_trk_phs=best_phs held stable throughout LOCK; tx_locked=1; tx_acq_rst=1.
REQ-022 LOCK: rx_trk_lost restarts search (as rx_start) with sweep=0.
REQ-023 FAIL: tx_fail=1, tx_acq_rst=1; rx_start restarts search.
REQ-024 tx_busy=1 in ARM, DWELL, EVAL only.
REQ-025 rx_abort in any state SHALL force IDLE next cycle, priority over rx_start, rx_acq_done, rx_trk_lost.
REQ-026 rx_start in ARM/DWELL/EVAL SHALL be ignored; rx_acq_done outside DWELL ignored.
REQ-027 rx_bin_step, rx_threshold SHALL be sampled each use (not latched); software changes them only in IDLE.

Reset
REQ-028 rx_rst SHALL force IDLE with tx_acq_rst=1, tx_car_fcw=0, tx_trk_fcw=0, tx_trk_phs=0, tx_trk_start=0, tx_busy=0, tx_locked=0, tx_fail=0, internal best_peak=0, sweep=0.
REQ-029 rx_rst mid-search SHALL take effect next cycle regardless of state; a coincident rx_acq_done is discarded.

Verification
REQ-030 HALF_BINS=4, step=1000, start; return done with peak 5 on all bins except bin +2 peak 900 phs 1234, threshold 500 -> tx_trk_start one pulse, tx_trk_fcw=2000, tx_trk_phs=1234, tx_locked=1, 9 dwells.
REQ-031 All peaks 100, threshold 500, MAX_SWEEPS=3 -> 27 dwells then tx_fail=1, tx_busy=0.
REQ-032 Bin -4 check: tx_car_fcw=32'hFFFFF060 (-4000) during first ARM; tx_acq_rst high exactly 2 cycles per ARM.
REQ-033 Peaks 700 at bins -1 and +3 (tie), threshold 500 -> lock with tx_trk_fcw=-1000.
REQ-034 rx_abort during DWELL coincident with rx_acq_done -> IDLE next cycle, no EVAL, best not updated; rx_rst in LOCK -> all outputs to reset values.
REQ-035 In LOCK pulse rx_trk_lost -> tx_locked=0, ARM at bin -4, new sweep count 0.

Source files
------------

// File: rtl/acq_doppler_sched_if.sv
// Signal bundle between the Doppler acquisition scheduler, its software controls,
// the acquisition engine and the tracking loop.
interface acq_doppler_sched_if #(
  parameter int unsigned ACC_WIDTH     = 32,
  parameter int unsigned CORR_WIDTH    = 32,
  parameter int unsigned PRN_PHS_WIDTH = 14
);
  logic                     rx_start;
  logic                     rx_abort;
  logic                     rx_trk_lost;
  logic [ACC_WIDTH-1:0]     rx_bin_step;
  logic [CORR_WIDTH-1:0]    rx_threshold;
  logic                     rx_acq_done;
  logic [CORR_WIDTH-1:0]    rx_acq_peak;
  logic [PRN_PHS_WIDTH-1:0] rx_acq_phs;

  logic                     tx_acq_rst;
  logic [ACC_WIDTH-1:0]     tx_car_fcw;
  logic                     tx_trk_start;
  logic [ACC_WIDTH-1:0]     tx_trk_fcw;
  logic [PRN_PHS_WIDTH-1:0] tx_trk_phs;
  logic                     tx_busy;
  logic                     tx_locked;
  logic                     tx_fail;

  modport master (
    output rx_start, rx_abort, rx_trk_lost, rx_bin_step, rx_threshold,
           rx_acq_done, rx_acq_peak, rx_acq_phs,
    input  tx_acq_rst, tx_car_fcw, tx_trk_start, tx_trk_fcw, tx_trk_phs,
           tx_busy, tx_locked, tx_fail
  );

  modport slave (
    input  rx_start, rx_abort, rx_trk_lost, rx_bin_step, rx_threshold,
           rx_acq_done, rx_acq_peak, rx_acq_phs,
    output tx_acq_rst, tx_car_fcw, tx_trk_start, tx_trk_fcw, tx_trk_phs,
           tx_busy, tx_locked, tx_fail
  );
endinterface

// File: rtl/acq_doppler_sched.sv
// Doppler bin search scheduler: sweeps the acquisition engine over 2*HALF_BINS+1
// carrier offsets, keeps the strongest peak and hands the winner to tracking.
module acq_doppler_sched #(
  parameter int unsigned ACC_WIDTH     = 32,
  parameter int unsigned CORR_WIDTH    = 32,
  parameter int unsigned PRN_PHS_WIDTH = 14,
  parameter int unsigned HALF_BINS     = 4,
  parameter int unsigned MAX_SWEEPS    = 3
) (
  input  logic                rx_clk,
  input  logic                rx_rst,
  acq_doppler_sched_if.slave  bus
);
  localparam int unsigned BIN_W = $clog2(HALF_BINS + 1) + 1;
  localparam int unsigned SWP_W = $clog2(MAX_SWEEPS + 1);
  localparam logic signed [BIN_W-1:0] BIN_MAX = BIN_W'(HALF_BINS);
  localparam logic signed [BIN_W-1:0] BIN_MIN = -BIN_MAX;

  typedef enum logic [2:0] {IDLE, ARM, DWELL, EVAL, LOCK, FAIL} state_e;

  state_e                   state_q, state_d;
  logic                     arm_cnt_q, arm_cnt_d;
  logic signed [BIN_W-1:0]  bin_q, bin_d;
  logic [SWP_W-1:0]         sweep_q, sweep_d;
  logic [CORR_WIDTH-1:0]    peak_q, peak_d;
  logic [PRN_PHS_WIDTH-1:0] phs_q, phs_d;
  logic [CORR_WIDTH-1:0]    best_peak_q, best_peak_d;
  logic [PRN_PHS_WIDTH-1:0] best_phs_q, best_phs_d;
  logic [ACC_WIDTH-1:0]     best_fcw_q, best_fcw_d;
  logic                     acq_rst_q, acq_rst_d;
  logic [ACC_WIDTH-1:0]     car_fcw_q, car_fcw_d;
  logic                     trk_start_q, trk_start_d;
  logic [ACC_WIDTH-1:0]     trk_fcw_q, trk_fcw_d;
  logic [PRN_PHS_WIDTH-1:0] trk_phs_q, trk_phs_d;
  logic                     busy_q, busy_d;
  logic                     locked_q, locked_d;
  logic                     fail_q, fail_d;

  logic                     restart;
  logic                     upd;
  logic [CORR_WIDTH-1:0]    new_peak;
  logic [PRN_PHS_WIDTH-1:0] new_phs;
  logic [ACC_WIDTH-1:0]     new_fcw;
  logic [SWP_W-1:0]         sweep_inc;

  // Carrier offset for a bin: sign-extended bin index times step, modulo 2^ACC_WIDTH.
  function automatic logic [ACC_WIDTH-1:0] fcw_of(input logic signed [BIN_W-1:0] b,
                                                  input logic [ACC_WIDTH-1:0]    step);
    logic [ACC_WIDTH-1:0] b_ext;
    b_ext = {{(ACC_WIDTH - BIN_W){b[BIN_W-1]}}, b};
    return b_ext * step;
  endfunction

  always_comb begin
    state_d     = state_q;
    arm_cnt_d   = arm_cnt_q;
    bin_d       = bin_q;
    sweep_d     = sweep_q;
    peak_d      = peak_q;
    phs_d       = phs_q;
    best_peak_d = best_peak_q;
    best_phs_d  = best_phs_q;
    best_fcw_d  = best_fcw_q;
    car_fcw_d   = car_fcw_q;
    trk_start_d = 1'b0;
    trk_fcw_d   = trk_fcw_q;
    trk_phs_d   = trk_phs_q;
    restart     = 1'b0;
    sweep_inc   = sweep_q + SWP_W'(1);

    // Strict compare keeps the earliest bin on equal peaks.
    upd      = peak_q > best_peak_q;
    new_peak = upd ? peak_q    : best_peak_q;
    new_phs  = upd ? phs_q     : best_phs_q;
    new_fcw  = upd ? car_fcw_q : best_fcw_q;

    if (bus.rx_abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  restart = bus.rx_start;
        ARM: begin
          if (arm_cnt_q) state_d = DWELL;
          else           arm_cnt_d = 1'b1;
        end
        DWELL: begin
          if (bus.rx_acq_done) begin
            peak_d  = bus.rx_acq_peak;
            phs_d   = bus.rx_acq_phs;
            state_d = EVAL;
          end
        end
        EVAL: begin
          best_peak_d = new_peak;
          best_phs_d  = new_phs;
          best_fcw_d  = new_fcw;
          if (bin_q < BIN_MAX) begin
            bin_d   = bin_q + BIN_W'(1);
            state_d = ARM;
          end else if (new_peak > bus.rx_threshold) begin
            state_d     = LOCK;
            trk_start_d = 1'b1;
            trk_fcw_d   = new_fcw;
            trk_phs_d   = new_phs;
          end else if (sweep_inc == SWP_W'(MAX_SWEEPS)) begin
            sweep_d = sweep_inc;
            state_d = FAIL;
          end else begin
            sweep_d     = sweep_inc;
            best_peak_d = '0;
            best_phs_d  = '0;
            best_fcw_d  = '0;
            bin_d       = BIN_MIN;
            state_d     = ARM;
          end
        end
        LOCK:  restart = bus.rx_trk_lost;
        FAIL:  restart = bus.rx_start;
        default: state_d = IDLE;
      endcase
    end

    if (restart) begin
      state_d     = ARM;
      bin_d       = BIN_MIN;
      sweep_d     = '0;
      best_peak_d = '0;
      best_phs_d  = '0;
      best_fcw_d  = '0;
    end

    // Offset is presented on the same cycle the engine reset goes high.
    if (state_d == ARM && state_q != ARM) begin
      arm_cnt_d = 1'b0;
      car_fcw_d = fcw_of(bin_d, bus.rx_bin_step);
    end

    acq_rst_d = !(state_d inside {DWELL, EVAL});
    busy_d    = state_d inside {ARM, DWELL, EVAL};
    locked_d  = state_d == LOCK;
    fail_d    = state_d == FAIL;
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q     <= IDLE;
      arm_cnt_q   <= 1'b0;
      bin_q       <= BIN_MIN;
      sweep_q     <= '0;
      peak_q      <= '0;
      phs_q       <= '0;
      best_peak_q <= '0;
      best_phs_q  <= '0;
      best_fcw_q  <= '0;
      acq_rst_q   <= 1'b1;
      car_fcw_q   <= '0;
      trk_start_q <= 1'b0;
      trk_fcw_q   <= '0;
      trk_phs_q   <= '0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_cnt_q   <= arm_cnt_d;
      bin_q       <= bin_d;
      sweep_q     <= sweep_d;
      peak_q      <= peak_d;
      phs_q       <= phs_d;
      best_peak_q <= best_peak_d;
      best_phs_q  <= best_phs_d;
      best_fcw_q  <= best_fcw_d;
      acq_rst_q   <= acq_rst_d;
      car_fcw_q   <= car_fcw_d;
      trk_start_q <= trk_start_d;
      trk_fcw_q   <= trk_fcw_d;
      trk_phs_q   <= trk_phs_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign bus.tx_acq_rst   = acq_rst_q;
  assign bus.tx_car_fcw   = car_fcw_q;
  assign bus.tx_trk_start = trk_start_q;
  assign bus.tx_trk_fcw   = trk_fcw_q;
  assign bus.tx_trk_phs   = trk_phs_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_locked    = locked_q;
  assign bus.tx_fail      = fail_q;
endmodule

// File: tb/tb_acq_doppler_sched.sv
// Directed bench for acq_doppler_sched: bin sweep, lock handoff, failure, tie, abort and reset.
module tb_acq_doppler_sched;
  localparam int unsigned ACC_W = 32;
  localparam int unsigned CORR_W = 32;
  localparam int unsigned PHS_W = 14;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pk [9];
  int   ph [9];

  acq_doppler_sched_if #(.ACC_WIDTH(ACC_W), .CORR_WIDTH(CORR_W), .PRN_PHS_WIDTH(PHS_W)) bus ();

  acq_doppler_sched #(.ACC_WIDTH(ACC_W), .CORR_WIDTH(CORR_W), .PRN_PHS_WIDTH(PHS_W),
                      .HALF_BINS(4), .MAX_SWEEPS(3))
    dut (.rx_clk(clk), .rx_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_table(input int base, input int bin_a, input int pa, input int bin_b, input int pb);
    for (int i = 0; i < 9; i++) begin pk[i] = base; ph[i] = 100 + i; end
    pk[bin_a + 4] = pa;
    pk[bin_b + 4] = pb;
  endtask

  task automatic pulse_start();
    bus.rx_start = 1'b1; @(negedge clk); bus.rx_start = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.rx_abort = 1'b1; @(negedge clk); bus.rx_abort = 1'b0;
  endtask

  // Acts as the acquisition engine: answers each dwell from the peak table until
  // lock, failure or the dwell budget.
  task automatic run_search(input int max_dwells, output int dwells, output bit timeout);
    int n;
    int b;
    dwells = 0; timeout = 1'b0;
    while (dwells < max_dwells) begin
      n = 0;
      while (!(bus.tx_busy && !bus.tx_acq_rst) && !bus.tx_locked && !bus.tx_fail && n < 50) begin
        @(negedge clk); n++;
      end
      if (n >= 50) begin timeout = 1'b1; return; end
      if (bus.tx_locked || bus.tx_fail) return;
      b = int'($signed(bus.tx_car_fcw)) / int'(bus.rx_bin_step);
      if (b < -4 || b > 4) begin
        bus.rx_acq_peak = '0; bus.rx_acq_phs = '0;
      end else begin
        bus.rx_acq_peak = CORR_W'(pk[b + 4]); bus.rx_acq_phs = PHS_W'(ph[b + 4]);
      end
      bus.rx_acq_done = 1'b1;
      @(negedge clk);
      bus.rx_acq_done = 1'b0;
      @(negedge clk);
      dwells++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.tx_acq_rst !== 1'b1) begin n_fail++; $display("FAIL rst_acq_rst: got %b want 1", bus.tx_acq_rst); end
    n_checks++; if (bus.tx_car_fcw !== 32'h0) begin n_fail++; $display("FAIL rst_car_fcw: got %h want 0", bus.tx_car_fcw); end
    n_checks++; if (bus.tx_trk_fcw !== 32'h0) begin n_fail++; $display("FAIL rst_trk_fcw: got %h want 0", bus.tx_trk_fcw); end
    n_checks++; if (bus.tx_trk_phs !== 14'h0) begin n_fail++; $display("FAIL rst_trk_phs: got %h want 0", bus.tx_trk_phs); end
    n_checks++; if ({bus.tx_trk_start, bus.tx_busy, bus.tx_locked, bus.tx_fail} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_flags: got %b want 0000", {bus.tx_trk_start, bus.tx_busy, bus.tx_locked, bus.tx_fail}); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_arm_window();
    int n;
    set_table(5, 0, 5, 0, 5);
    pulse_start();
    n_checks++; if (bus.tx_car_fcw !== 32'hFFFFF060) begin n_fail++; $display("FAIL arm_fcw_m4: got %h want FFFFF060", bus.tx_car_fcw); end
    n_checks++; if (bus.tx_acq_rst !== 1'b1 || bus.tx_busy !== 1'b1) begin n_fail++; $display("FAIL arm1_flags: got rst=%b busy=%b want 1 1", bus.tx_acq_rst, bus.tx_busy); end
    @(negedge clk);
    n_checks++; if (bus.tx_acq_rst !== 1'b1) begin n_fail++; $display("FAIL arm2_rst: got %b want 1", bus.tx_acq_rst); end
    @(negedge clk);
    n_checks++; if (bus.tx_acq_rst !== 1'b0 || bus.tx_busy !== 1'b1) begin n_fail++; $display("FAIL dwell_flags: got rst=%b busy=%b want 0 1", bus.tx_acq_rst, bus.tx_busy); end
    bus.rx_acq_peak = 32'd5; bus.rx_acq_done = 1'b1;
    @(negedge clk); bus.rx_acq_done = 1'b0;
    n_checks++; if (bus.tx_acq_rst !== 1'b0 || bus.tx_busy !== 1'b1) begin n_fail++; $display("FAIL eval_flags: got rst=%b busy=%b want 0 1", bus.tx_acq_rst, bus.tx_busy); end
    @(negedge clk);
    n_checks++; if (bus.tx_car_fcw !== 32'hFFFFF448) begin n_fail++; $display("FAIL arm_fcw_m3: got %h want FFFFF448", bus.tx_car_fcw); end
    n = 0;
    while (bus.tx_acq_rst && n < 10) begin n++; @(negedge clk); end
    n_checks++; if (n != 2) begin n_fail++; $display("FAIL arm_len: got %0d cycles want 2", n); end
    pulse_abort();
    n_checks++; if (bus.tx_busy !== 1'b0 || bus.tx_acq_rst !== 1'b1) begin n_fail++; $display("FAIL abort_idle: got busy=%b rst=%b want 0 1", bus.tx_busy, bus.tx_acq_rst); end
  endtask

  task automatic test_lock();
    int d; bit to;
    set_table(5, 2, 900, 2, 900);
    ph[6] = 1234;
    pulse_start();
    run_search(100, d, to);
    n_checks++; if (to || d != 9) begin n_fail++; $display("FAIL lock_dwells: got %0d (timeout=%0b) want 9", d, to); end
    n_checks++; if (bus.tx_trk_start !== 1'b1) begin n_fail++; $display("FAIL lock_start: got %b want 1", bus.tx_trk_start); end
    n_checks++; if (bus.tx_trk_fcw !== 32'd2000) begin n_fail++; $display("FAIL lock_fcw: got %0d want 2000", bus.tx_trk_fcw); end
    n_checks++; if (bus.tx_trk_phs !== 14'd1234) begin n_fail++; $display("FAIL lock_phs: got %0d want 1234", bus.tx_trk_phs); end
    n_checks++; if (bus.tx_locked !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_acq_rst !== 1'b1) begin
      n_fail++; $display("FAIL lock_flags: got locked=%b busy=%b rst=%b want 1 0 1", bus.tx_locked, bus.tx_busy, bus.tx_acq_rst); end
    @(negedge clk);
    n_checks++; if (bus.tx_trk_start !== 1'b0) begin n_fail++; $display("FAIL lock_start_pulse: got %b want 0", bus.tx_trk_start); end
    repeat (4) @(negedge clk);
    n_checks++; if (bus.tx_locked !== 1'b1 || bus.tx_trk_fcw !== 32'd2000 || bus.tx_trk_phs !== 14'd1234) begin
      n_fail++; $display("FAIL lock_hold: got locked=%b fcw=%0d phs=%0d want 1 2000 1234", bus.tx_locked, bus.tx_trk_fcw, bus.tx_trk_phs); end
  endtask

  task automatic test_trk_lost_and_fail();
    int d; bit to;
    set_table(100, 0, 100, 0, 100);
    bus.rx_trk_lost = 1'b1; @(negedge clk); bus.rx_trk_lost = 1'b0;
    n_checks++; if (bus.tx_locked !== 1'b0 || bus.tx_busy !== 1'b1 || bus.tx_car_fcw !== 32'hFFFFF060) begin
      n_fail++; $display("FAIL lost_rearm: got locked=%b busy=%b fcw=%h want 0 1 FFFFF060", bus.tx_locked, bus.tx_busy, bus.tx_car_fcw); end
    run_search(9, d, to);
    n_checks++; if (to || d != 9 || bus.tx_busy !== 1'b1 || bus.tx_car_fcw !== 32'hFFFFF060) begin
      n_fail++; $display("FAIL sweep_wrap: got d=%0d busy=%b fcw=%h want 9 1 FFFFF060", d, bus.tx_busy, bus.tx_car_fcw); end
    set_table(5, -2, 800, -2, 800);
    run_search(100, d, to);
    n_checks++; if (to || d != 9 || bus.tx_locked !== 1'b1 || bus.tx_trk_fcw !== 32'hFFFFF830) begin
      n_fail++; $display("FAIL relock: got d=%0d locked=%b fcw=%h want 9 1 FFFFF830", d, bus.tx_locked, bus.tx_trk_fcw); end
    set_table(100, 0, 100, 0, 100);
    bus.rx_trk_lost = 1'b1; @(negedge clk); bus.rx_trk_lost = 1'b0;
    run_search(100, d, to);
    n_checks++; if (to || d != 27) begin n_fail++; $display("FAIL fail_dwells: got %0d (timeout=%0b) want 27", d, to); end
    n_checks++; if (bus.tx_fail !== 1'b1 || bus.tx_busy !== 1'b0 || bus.tx_acq_rst !== 1'b1) begin
      n_fail++; $display("FAIL fail_flags: got fail=%b busy=%b rst=%b want 1 0 1", bus.tx_fail, bus.tx_busy, bus.tx_acq_rst); end
    pulse_start();
    n_checks++; if (bus.tx_fail !== 1'b0 || bus.tx_busy !== 1'b1 || bus.tx_car_fcw !== 32'hFFFFF060) begin
      n_fail++; $display("FAIL fail_restart: got fail=%b busy=%b fcw=%h want 0 1 FFFFF060", bus.tx_fail, bus.tx_busy, bus.tx_car_fcw); end
    pulse_abort();
  endtask

  task automatic test_threshold_equal();
    int d; bit to;
    set_table(100, 4, 500, 4, 500);
    pulse_start();
    run_search(9, d, to);
    n_checks++; if (to || d != 9 || bus.tx_locked !== 1'b0 || bus.tx_busy !== 1'b1) begin
      n_fail++; $display("FAIL thr_equal: got d=%0d locked=%b busy=%b want 9 0 1", d, bus.tx_locked, bus.tx_busy); end
    pulse_abort();
  endtask

  task automatic test_tie();
    int d; bit to;
    set_table(100, -1, 700, 3, 700);
    pulse_start();
    run_search(100, d, to);
    n_checks++; if (to || d != 9 || bus.tx_locked !== 1'b1) begin n_fail++; $display("FAIL tie_lock: got d=%0d locked=%b want 9 1", d, bus.tx_locked); end
    n_checks++; if (bus.tx_trk_fcw !== 32'hFFFFFC18 || bus.tx_trk_phs !== 14'd103) begin
      n_fail++; $display("FAIL tie_fcw: got fcw=%h phs=%0d want FFFFFC18 103", bus.tx_trk_fcw, bus.tx_trk_phs); end
  endtask

  task automatic test_abort_and_reset();
    int n; logic [31:0] f;
    pulse_abort();
    pulse_start();
    n = 0;
    while (!(bus.tx_busy && !bus.tx_acq_rst) && n < 20) begin @(negedge clk); n++; end
    n_checks++; if (n >= 20) begin n_fail++; $display("FAIL dwell_wait: no dwell within %0d cycles", n); end
    f = bus.tx_car_fcw;
    pulse_start();
    n_checks++; if (bus.tx_acq_rst !== 1'b0 || bus.tx_busy !== 1'b1 || bus.tx_car_fcw !== f) begin
      n_fail++; $display("FAIL start_ignored: got rst=%b busy=%b fcw=%h want 0 1 %h", bus.tx_acq_rst, bus.tx_busy, bus.tx_car_fcw, f); end
    bus.rx_acq_peak = 32'd900; bus.rx_acq_done = 1'b1; bus.rx_abort = 1'b1;
    @(negedge clk);
    bus.rx_acq_done = 1'b0; bus.rx_abort = 1'b0;
    n_checks++; if (bus.tx_busy !== 1'b0 || bus.tx_acq_rst !== 1'b1 || bus.tx_locked !== 1'b0) begin
      n_fail++; $display("FAIL abort_done: got busy=%b rst=%b locked=%b want 0 1 0", bus.tx_busy, bus.tx_acq_rst, bus.tx_locked); end
    bus.rx_acq_done = 1'b1; @(negedge clk); bus.rx_acq_done = 1'b0; @(negedge clk);
    n_checks++; if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_done_ignored: got busy=%b want 0", bus.tx_busy); end
    test_tie();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.tx_acq_rst !== 1'b1 || bus.tx_car_fcw !== 32'h0 || bus.tx_trk_fcw !== 32'h0 || bus.tx_trk_phs !== 14'h0) begin
      n_fail++; $display("FAIL lock_rst_data: got rst=%b car=%h trk=%h phs=%h want 1 0 0 0", bus.tx_acq_rst, bus.tx_car_fcw, bus.tx_trk_fcw, bus.tx_trk_phs); end
    n_checks++; if ({bus.tx_trk_start, bus.tx_busy, bus.tx_locked, bus.tx_fail} !== 4'b0000) begin
      n_fail++; $display("FAIL lock_rst_flags: got %b want 0000", {bus.tx_trk_start, bus.tx_busy, bus.tx_locked, bus.tx_fail}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.rx_start = 1'b0; bus.rx_abort = 1'b0; bus.rx_trk_lost = 1'b0;
    bus.rx_bin_step = 32'd1000; bus.rx_threshold = 32'd500;
    bus.rx_acq_done = 1'b0; bus.rx_acq_peak = '0; bus.rx_acq_phs = '0;
    rst = 1'b1;
    test_reset();
    test_arm_window();
    test_lock();
    test_trk_lost_and_fail();
    test_threshold_equal();
    test_tie();
    test_abort_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
